// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous-read RAM between the instruction fetcher and the LSB,
//   with the LSB served first. Each 1/2/4-byte access runs as consecutive byte cycles, and loads are extended.
// Latency: the request is accepted on edge E0. Reads complete at E(N+1) (word 5, byte 2).
//   Writes complete at E(N), plus one edge for every I/O stall edge.
// Backpressure: requests are levels held until the matching done pulse. rdy=0 freezes all state.
//   I/O-region writes wait while io_buffer_full is high.
// Ports: clk, rst (async, active-high), rdy (global hold), clear (fetch flush);
//   if_req/if_addr -> if_done/if_data;
//   lsb_rn/lsb_wn/lsb_addr/lsb_wvalue/lsb_size/lsb_signed -> lsb_done/lsb_rdata;
//   mem_din <- RAM, mem_dout/mem_a/mem_wr -> RAM; io_buffer_full from the I/O output buffer.
module mem_arbiter #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 32'h0003_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clear,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  lsb_rn,
    input  logic                  lsb_wn,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [31:0]           lsb_wvalue,
    input  logic [1:0]            lsb_size,
    input  logic                  lsb_signed,
    output logic                  lsb_done,
    output logic [31:0]           lsb_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                  state;
    logic                    owner_if;   // 1: fetcher owns the access, 0: LSB
    logic [ADDR_WIDTH-1:0]   addr;
    logic [2:0]              len;        // byte count: 1, 2 or 4
    logic                    sgn;
    logic [31:0]             wdata;
    logic [2:0]              cnt;        // READ: edges since accept; WRITE: bytes issued so far
    logic [31:0]             rbuf;

    logic [2:0]              req_len;
    logic [ADDR_WIDTH-1:0]   next_a;
    logic [1:0]              cap_idx;
    logic [31:0]             rword;
    logic [31:0]             rext;
    logic [7:0]              wbyte;
    logic                    io_stall;
    logic                    accept_stall;

    always_comb begin
        case (lsb_size)
            2'b00:   req_len = 3'd1;
            2'b01:   req_len = 3'd2;
            default: req_len = 3'd4;
        endcase
    end

    // Byte address for the current step; wraps naturally at the address width.
    assign next_a = addr + {{(ADDR_WIDTH-3){1'b0}}, cnt};

    // The byte arriving on this edge belongs to the address presented two edges ago.
    assign cap_idx = cnt[1:0] - 2'd2;

    always_comb begin
        rword = rbuf;
        rword[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        rext = rword;
        if (len == 3'd1) begin
            rext = {{24{sgn & rword[7]}}, rword[7:0]};
        end else if (len == 3'd2) begin
            rext = {{16{sgn & rword[15]}}, rword[15:0]};
        end
    end

    assign wbyte        = wdata[{cnt[1:0], 3'b000} +: 8];
    assign io_stall     = (addr >= IO_BASE) && io_buffer_full;
    assign accept_stall = (lsb_addr >= IO_BASE) && io_buffer_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_if  <= 1'b0;
            addr      <= '0;
            len       <= 3'd0;
            sgn       <= 1'b0;
            wdata     <= 32'h0;
            cnt       <= 3'd0;
            rbuf      <= 32'h0;
            if_done   <= 1'b0;
            if_data   <= 32'h0;
            lsb_done  <= 1'b0;
            lsb_rdata <= 32'h0;
            mem_dout  <= 8'h0;
            mem_a     <= '0;
            mem_wr    <= 1'b0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (lsb_wn) begin
                        // A simultaneous load request is ignored; the write wins.
                        owner_if <= 1'b0;
                        addr     <= lsb_addr;
                        len      <= req_len;
                        sgn      <= lsb_signed;
                        wdata    <= lsb_wvalue;
                        state    <= WRITE;
                        if (accept_stall) begin
                            mem_wr <= 1'b0;
                            cnt    <= 3'd0;
                        end else begin
                            mem_wr   <= 1'b1;
                            mem_a    <= lsb_addr;
                            mem_dout <= lsb_wvalue[7:0];
                            cnt      <= 3'd1;
                        end
                    end else if (lsb_rn) begin
                        owner_if <= 1'b0;
                        addr     <= lsb_addr;
                        len      <= req_len;
                        sgn      <= lsb_signed;
                        rbuf     <= 32'h0;
                        mem_a    <= lsb_addr;
                        cnt      <= 3'd1;
                        state    <= READ;
                    end else if (if_req && !clear) begin
                        owner_if <= 1'b1;
                        addr     <= if_addr;
                        len      <= 3'd4;
                        sgn      <= 1'b0;
                        rbuf     <= 32'h0;
                        mem_a    <= if_addr;
                        cnt      <= 3'd1;
                        state    <= READ;
                    end
                end

                READ: begin
                    if (owner_if && clear) begin
                        // Flushed fetch: drop partial data and leave mem_a where it is.
                        state <= IDLE;
                    end else begin
                        if (cnt < len) begin
                            mem_a <= next_a;
                        end
                        if (cnt >= 3'd2) begin
                            rbuf <= rword;
                        end
                        if (cnt == len + 3'd1) begin
                            if (owner_if) begin
                                if_done <= 1'b1;
                                if_data <= rext;
                            end else begin
                                lsb_done  <= 1'b1;
                                lsb_rdata <= rext;
                            end
                            state <= DONE;
                        end
                        cnt <= cnt + 3'd1;
                    end
                end

                WRITE: begin
                    if (cnt == len) begin
                        mem_wr   <= 1'b0;
                        lsb_done <= 1'b1;
                        state    <= DONE;
                    end else if (io_stall) begin
                        mem_wr <= 1'b0;
                    end else begin
                        mem_wr   <= 1'b1;
                        mem_a    <= next_a;
                        mem_dout <= wbyte;
                        cnt      <= cnt + 3'd1;
                    end
                end

                DONE: begin
                    // Gives the requester one cycle to drop its level request.
                    if_done  <= 1'b0;
                    lsb_done <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a transaction-level expectation model.
// Latency: expectations are indexed by the count of active (rdy=1) edges since reset.
// Backpressure: the bench drives rdy, io_buffer_full and clear directly from the stimulus.
module tb_mem_arbiter;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;
    localparam int          DEPTH   = 1024;
    localparam int          HA = 0, HD = 1, HI = 2, HL = 3;  // held-value fields

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        clear = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_rn = 1'b0;
    logic        lsb_wn = 1'b0;
    logic [31:0] lsb_addr = 32'h0;
    logic [31:0] lsb_wvalue = 32'h0;
    logic [1:0]  lsb_size = 2'b00;
    logic        lsb_signed = 1'b0;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din = 8'h0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int t_edge  = 0;
    bit run     = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .IO_BASE(IO_BASE)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_rn(lsb_rn), .lsb_wn(lsb_wn), .lsb_addr(lsb_addr), .lsb_wvalue(lsb_wvalue),
        .lsb_size(lsb_size), .lsb_signed(lsb_signed), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // System RAM: synchronous read, paused together with the rest of the system by rdy.
    logic [7:0] ram     [bit [31:0]];
    // Reference memory: updated only by the model's view of completed store bytes.
    logic [7:0] ref_mem [bit [31:0]];

    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) ram[mem_a] = mem_dout;
            mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        end
    end

    always @(posedge clk) begin
        if (!rst && rdy) t_edge <= t_edge + 1;
    end

    // Expected outputs per active edge: pulses default to 0, data outputs hold their last value.
    bit          x_wr  [DEPTH];
    bit          x_ifd [DEPTH];
    bit          x_lsd [DEPTH];
    bit          hset  [4][DEPTH];
    logic [31:0] hval  [4][DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d time=%0t got=%h want=%h", nm, t_edge, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] held(input int f, input int t);
        for (int i = t; i >= 0; i--) begin
            if (hset[f][i]) return hval[f][i];
        end
        return 32'h0;
    endfunction

    task automatic set_h(input int f, input int t, input logic [31:0] v);
        if (t < DEPTH) begin
            hset[f][t] = 1'b1;
            hval[f][t] = v;
        end
    endtask

    task automatic put(input logic [31:0] a, input logic [7:0] b);
        ram[a]     = b;
        ref_mem[a] = b;
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Little-endian value of n bytes, then two's-complement reinterpretation for signed sub-word loads.
    function automatic logic [31:0] expect_load(input logic [31:0] a, input int n, input bit sg);
        longint v = 0;
        for (int k = 0; k < n; k++) v += longint'(ref_byte(a + k)) << (8 * k);
        if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    // Read accepted at edge t0: byte addresses on t0..t0+n-1, result at t0+n+1.
    // cut>0 means the access is flushed on edge t0+cut.
    task automatic sched_read(input int t0, input logic [31:0] a, input int n, input bit sg,
                              input bit is_fetch, input int cut);
        logic [31:0] v;
        for (int k = 0; k < n; k++) begin
            if (cut == 0 || k < cut) set_h(HA, t0 + k, a + k);
        end
        if (cut == 0) begin
            v = expect_load(a, n, sg);
            if (is_fetch) begin
                x_ifd[t0 + n + 1] = 1'b1;
                set_h(HI, t0 + n + 1, v);
            end else begin
                x_lsd[t0 + n + 1] = 1'b1;
                set_h(HL, t0 + n + 1, v);
            end
        end
    endtask

    // Store accepted at edge t0: one byte per edge unless an I/O address meets a full buffer.
    // io_buffer_full is high for edges t0..t0+full_edges-1.
    task automatic sched_write(input int t0, input logic [31:0] a, input int n, input logic [31:0] d,
                               input int full_edges, output int t_done);
        int t = t0;
        int k = 0;
        while (k < n) begin
            if (a >= IO_BASE && t < t0 + full_edges) begin
                x_wr[t] = 1'b0;
            end else begin
                x_wr[t] = 1'b1;
                set_h(HA, t, a + k);
                set_h(HD, t, 32'(d[8 * k +: 8]));
                ref_mem[a + k] = d[8 * k +: 8];
                k++;
            end
            t++;
        end
        x_lsd[t] = 1'b1;
        t_done = t;
    endtask

    always @(negedge clk) begin
        int t;
        if (run) begin
            t = t_edge;
            chk("mem_a",     mem_a,            held(HA, t));
            chk("mem_wr",    32'(mem_wr),      32'(x_wr[t]));
            chk("mem_dout",  32'(mem_dout),    held(HD, t));
            chk("if_done",   32'(if_done),     32'(x_ifd[t]));
            chk("if_data",   if_data,          held(HI, t));
            chk("lsb_done",  32'(lsb_done),    32'(x_lsd[t]));
            chk("lsb_rdata", lsb_rdata,        held(HL, t));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input bit sg,
                           input logic [31:0] lit, input string nm);
        int n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        lsb_rn = 1'b1; lsb_addr = a; lsb_size = sz; lsb_signed = sg;
        sched_read(t_edge + 1, a, n, sg, 1'b0, 0);
        step(n + 2);
        chk(nm, lsb_rdata, lit);
        chk({nm, "_done"}, 32'(lsb_done), 32'h1);
        lsb_rn = 1'b0;
        step(1);
    endtask

    initial begin
        int t0;
        int td;

        put(32'h100, 8'h13); put(32'h101, 8'h05); put(32'h102, 8'h10); put(32'h103, 8'h00);
        put(32'h200, 8'h93); put(32'h201, 8'h00); put(32'h202, 8'h10); put(32'h203, 8'h00);
        put(32'h2000, 8'h80);
        put(32'h2004, 8'h34); put(32'h2005, 8'hF2);
        put(32'h2010, 8'h11); put(32'h2011, 8'h22); put(32'h2012, 8'h33); put(32'h2013, 8'h44);
        put(32'hFFFF_FFFE, 8'hAA); put(32'hFFFF_FFFF, 8'hBB); put(32'h0, 8'hCC); put(32'h1, 8'hDD);

        #2 rst = 1'b1;
        step(2);
        chk("rst_mem_wr",   32'(mem_wr),   32'h0);
        chk("rst_mem_a",    mem_a,         32'h0);
        chk("rst_if_done",  32'(if_done),  32'h0);
        chk("rst_lsb_done", 32'(lsb_done), 32'h0);
        rst = 1'b0; rdy = 1'b1; run = 1'b1;
        step(1);

        // Word fetch; the request stays up through the DONE edge, which must not accept it.
        if_req = 1'b1; if_addr = 32'h100;
        t0 = t_edge + 1;
        sched_read(t0, 32'h100, 4, 1'b0, 1'b1, 0);
        step(6);
        chk("fetch_done", 32'(if_done), 32'h1);
        chk("fetch_data", if_data, 32'h0010_0513);
        step(1);
        chk("fetch_pulse_end", 32'(if_done), 32'h0);
        chk("fetch_done_no_accept", mem_a, 32'h103);
        if_req = 1'b0;
        step(1);

        do_load(32'h2000, 2'b00, 1'b1, 32'hFFFF_FF80, "lb_signed");
        do_load(32'h2000, 2'b00, 1'b0, 32'h0000_0080, "lb_unsigned");
        do_load(32'h2004, 2'b01, 1'b1, 32'hFFFF_F234, "lh_signed");

        // Half store: two write cycles, then done.
        lsb_wn = 1'b1; lsb_rn = 1'b1; lsb_addr = 32'h2002; lsb_wvalue = 32'hDEAD_BEEF; lsb_size = 2'b01;
        t0 = t_edge + 1;
        sched_write(t0, 32'h2002, 2, 32'hDEAD_BEEF, 0, td);
        step(1);
        chk("sh_wr0",   32'(mem_wr), 32'h1);
        chk("sh_a0",    mem_a, 32'h2002);
        chk("sh_d0",    32'(mem_dout), 32'hEF);
        step(1);
        chk("sh_a1",    mem_a, 32'h2003);
        chk("sh_d1",    32'(mem_dout), 32'hBE);
        step(1);
        chk("sh_done",  32'(lsb_done), 32'h1);
        chk("sh_wr_off", 32'(mem_wr), 32'h0);
        lsb_wn = 1'b0; lsb_rn = 1'b0;
        step(1);
        do_load(32'h2002, 2'b01, 1'b0, 32'h0000_BEEF, "lhu_after_sh");

        // Fetch and load raised together: the LSB goes first, the fetch follows its DONE edge.
        lsb_rn = 1'b1; lsb_addr = 32'h2004; lsb_size = 2'b01; lsb_signed = 1'b0;
        if_req = 1'b1; if_addr = 32'h200;
        t0 = t_edge + 1;
        sched_read(t0, 32'h2004, 2, 1'b0, 1'b0, 0);
        sched_read(t0 + 5, 32'h200, 4, 1'b0, 1'b1, 0);
        step(4);
        chk("prio_lsb_data", lsb_rdata, 32'h0000_F234);
        chk("prio_if_wait", 32'(if_done), 32'h0);
        lsb_rn = 1'b0;
        step(7);
        chk("prio_fetch_done", 32'(if_done), 32'h1);
        chk("prio_fetch_data", if_data, 32'h0010_0093);
        if_req = 1'b0;
        step(1);

        // Size 11 is a word; the address wraps past the top of the space.
        do_load(32'hFFFF_FFFE, 2'b11, 1'b1, 32'hDDCC_BBAA, "lw_wrap");

        // I/O byte store held off by a full buffer for three edges.
        lsb_wn = 1'b1; lsb_addr = 32'h0003_0000; lsb_wvalue = 32'h0000_005A; lsb_size = 2'b00;
        io_buffer_full = 1'b1;
        t0 = t_edge + 1;
        sched_write(t0, 32'h0003_0000, 1, 32'h0000_005A, 3, td);
        step(3);
        chk("io_stalled", 32'(mem_wr), 32'h0);
        io_buffer_full = 1'b0;
        step(1);
        chk("io_wr", 32'(mem_wr), 32'h1);
        chk("io_a",  mem_a, 32'h0003_0000);
        chk("io_d",  32'(mem_dout), 32'h5A);
        step(1);
        chk("io_done", 32'(lsb_done), 32'h1);
        lsb_wn = 1'b0;
        step(1);

        // Just below the I/O base a full buffer must not stall the store.
        lsb_wn = 1'b1; lsb_addr = 32'h0002_FFFC; lsb_wvalue = 32'h1234_5678; lsb_size = 2'b10;
        io_buffer_full = 1'b1;
        t0 = t_edge + 1;
        sched_write(t0, 32'h0002_FFFC, 4, 32'h1234_5678, 100, td);
        step(td - t0 + 1);
        chk("below_io_done", 32'(lsb_done), 32'h1);
        lsb_wn = 1'b0; io_buffer_full = 1'b0;
        step(1);
        do_load(32'h0002_FFFC, 2'b10, 1'b0, 32'h1234_5678, "lw_below_io");

        // Flush two edges into a fetch, then prove IDLE by an immediate LSB accept.
        if_req = 1'b1; if_addr = 32'h100;
        t0 = t_edge + 1;
        sched_read(t0, 32'h100, 4, 1'b0, 1'b1, 2);
        step(2);
        clear = 1'b1; if_req = 1'b0;
        step(1);
        clear = 1'b0;
        chk("flush_no_done", 32'(if_done), 32'h0);
        chk("flush_mem_a", mem_a, 32'h101);
        do_load(32'h2000, 2'b00, 1'b0, 32'h0000_0080, "lb_after_flush");

        // clear in IDLE blocks a fetch for that edge only.
        clear = 1'b1; if_req = 1'b1; if_addr = 32'h200;
        t0 = t_edge + 1;
        sched_read(t0 + 1, 32'h200, 4, 1'b0, 1'b1, 0);
        step(1);
        clear = 1'b0;
        step(6);
        chk("idle_clear_fetch", if_data, 32'h0010_0093);
        if_req = 1'b0;
        step(1);

        // clear never aborts LSB traffic.
        clear = 1'b1;
        do_load(32'h2004, 2'b01, 1'b1, 32'hFFFF_F234, "lh_under_clear");
        clear = 1'b0;

        // Four rdy=0 cycles inside a word load.
        lsb_rn = 1'b1; lsb_addr = 32'h2010; lsb_size = 2'b10; lsb_signed = 1'b1;
        t0 = t_edge + 1;
        sched_read(t0, 32'h2010, 4, 1'b1, 1'b0, 0);
        step(2);
        rdy = 1'b0;
        step(4);
        chk("rdy_freeze_a", mem_a, 32'h2011);
        rdy = 1'b1;
        step(3);
        chk("rdy_not_yet", 32'(lsb_done), 32'h0);
        step(1);
        chk("rdy_done", 32'(lsb_done), 32'h1);
        chk("rdy_data", lsb_rdata, 32'h4433_2211);
        lsb_rn = 1'b0;
        step(1);

        // Reset in the middle of a word store.
        lsb_wn = 1'b1; lsb_addr = 32'h2100; lsb_wvalue = 32'hCAFE_F00D; lsb_size = 2'b10;
        t0 = t_edge + 1;
        sched_write(t0, 32'h2100, 4, 32'hCAFE_F00D, 0, td);
        step(2);
        run = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_wr",    32'(mem_wr),   32'h0);
        chk("midrst_a",     mem_a,         32'h0);
        chk("midrst_dout",  32'(mem_dout), 32'h0);
        chk("midrst_rdata", lsb_rdata,     32'h0);
        chk("midrst_idata", if_data,       32'h0);
        lsb_wn = 1'b0;
        step(1);
        rst = 1'b0;
        step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the instruction fetcher and the load/store buffer (LSB) on one side, and the single byte-wide, synchronous-read system RAM on the other.
- Arbitrates the RAM between the two requesters (LSB has priority).
- Sequences each 1/2/4-byte access as consecutive byte transactions.
- Assembles and sign/zero-extends load data, and stalls stores to the I/O region while the I/O buffer is full.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are I/O; writes to them obey io_buffer_full.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rdy  in  1  global ready; when low, all internal registers and outputs hold their values
- clear  in  1  pipeline flush from ROB; aborts an in-flight fetch only
- if_req  in  1  fetch request, level; held until if_done
- if_addr  in  ADDR_WIDTH  fetch address (always a 4-byte read)
- if_done  out  1  one-cycle pulse; if_data valid in the same cycle
- if_data  out  32  fetched word
- lsb_rn  in  1  load request, level; held until lsb_done
- lsb_wn  in  1  store request, level; held until lsb_done
- lsb_addr  in  ADDR_WIDTH  access address
- lsb_wvalue  in  32  store data
- lsb_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- lsb_signed  in  1  loads: 1 sign-extend, 0 zero-extend
- lsb_done  out  1  one-cycle pulse; lsb_rdata valid in the same cycle for loads
- lsb_rdata  out  32  extended load result
- mem_din  in  8  RAM read data; valid the cycle after its address is presented
- mem_dout  out  8  RAM write data
- mem_a  out  ADDR_WIDTH  RAM byte address
- mem_wr  out  1  RAM write strobe (1 = write)
- io_buffer_full  in  1  I/O output buffer full

Behaviour:
- Reset: state IDLE, counters 0; if_done, lsb_done, mem_wr, mem_a, mem_dout, if_data and lsb_rdata all 0.
- All outputs are registered. Nothing advances on an edge where rdy=0.
- States: IDLE, READ, WRITE, DONE.
  - IDLE: accepts at most one request per edge. Priority is lsb_wn, then lsb_rn, then if_req.
    - If lsb_wn and lsb_rn are both high, the request is a write.
    - On accept: latch addr, size (N = 1/2/4; fetch N = 4), signed flag, wdata and owner; go to READ or WRITE.
  - READ, with accept edge E0:
    - mem_a <= addr+k at edge E_k, k = 0..N-1.
    - At edge E_{k+2}, mem_din is captured into bits [8k+7:8k] (little-endian).
    - At E_{N+1}: final byte captured, owner's done <= 1 with data, state <= DONE.
    - Latency: word load/fetch done at E5; byte load at E2.
  - WRITE:
    - At E_k: mem_wr <= 1, mem_a <= addr+k, mem_dout <= wdata[8k+7:8k].
    - At E_N: mem_wr <= 0, lsb_done <= 1, state <= DONE.
    - I/O stall: if addr >= IO_BASE and io_buffer_full=1 at the edge that would issue a byte, drive mem_wr <= 0 and do not advance k. Resume on the first edge with io_buffer_full=0.
  - DONE: done pulses clear to 0, state <= IDLE. No request is accepted on this edge, so the requester has one cycle to drop its request.
- Load extension (byte/half, applied at the final capture):
  - signed: replicate bit 7 / bit 15 upward.
  - unsigned: zero upper bits.
  - Word loads are passed through unchanged.
- Flush:
  - clear=1 while the owner is the fetcher (READ state): go to IDLE, no if_done, mem_a unchanged, partial data discarded.
  - clear=1 in IDLE: if_req is ignored on that edge; LSB requests are still accepted.
  - LSB operations are never aborted by clear.
- Address arithmetic: addr+k wraps modulo 2^ADDR_WIDTH.
- rst asserted mid-access: immediate return to reset values, including mem_wr=0. A partially written store is not completed.

Test Plan:
- if_req=1, if_addr=0x100; RAM bytes 0x13,0x05,0x10,0x00 -> mem_a = 0x100..0x103 on consecutive edges; if_done pulses at accept+5 with if_data=0x00100513; then one DONE cycle with no accept.
- lsb_rn=1, lsb_size=00, lsb_signed=1, byte 0x80 at 0x2000 -> lsb_done at accept+2, lsb_rdata=0xFFFFFF80. Repeat with lsb_signed=0 -> 0x00000080.
- lsb_wn=1, size=01, addr=0x2002, wvalue=0xDEADBEEF -> mem_wr=1 for 2 cycles, (0x2002,0xEF) then (0x2003,0xBE); lsb_done one cycle later.
- if_req and lsb_rn raised on the same edge -> LSB served first; fetch starts on the edge after the DONE cycle and completes correctly.
- lsb_wn=1, size=00, addr=0x30000, io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for those cycles, byte written on the first cycle after it drops; clear asserted 2 cycles into a fetch -> no if_done, state IDLE next cycle.
- rdy=0 for 4 cycles during a word load -> mem_a and the captured bytes freeze; lsb_done is delayed by exactly 4 cycles with correct data.
